// File: rtl/exec_stage_pkg.sv
// Shared types for the execute stage and register file: register/selector types, opcodes, instruction fields.
package exec_stage_pkg;

    typedef logic [15:0] reg16_t;
    typedef logic [2:0]  reg_sel_t;

    // Opcodes 8..15 carry no name and execute as NOP.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_MOV  = 4'd5,
        OP_MUL  = 4'd6,
        OP_ADDI = 4'd7
    } op_t;

    localparam int OP_LSB  = 12;
    localparam int D_LSB   = 9;
    localparam int N_LSB   = 6;
    localparam int M_LSB   = 3;
    localparam int IMM_LSB = 0;

    function automatic logic [3:0] get_op(input reg16_t w);
        return w[OP_LSB +: 4];
    endfunction

    function automatic reg_sel_t get_d(input reg16_t w);
        return w[D_LSB +: 3];
    endfunction

    function automatic reg_sel_t get_n(input reg16_t w);
        return w[N_LSB +: 3];
    endfunction

    function automatic reg_sel_t get_m(input reg16_t w);
        return w[M_LSB +: 3];
    endfunction

    function automatic logic [2:0] get_imm(input reg16_t w);
        return w[IMM_LSB +: 3];
    endfunction

endpackage

// File: rtl/mul16_iter.sv
// Iterative 16x16 shift-add multiplier keeping the low 16 product bits, one partial product per cycle.
// done is high during the 16th iteration; product is final from the following cycle until the next start.
module mul16_iter
    import exec_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  reg16_t a,
    input  reg16_t b,
    output logic   done,
    output reg16_t product
);

    reg16_t     a_sh;
    reg16_t     b_sh;
    reg16_t     acc;
    logic [3:0] cnt;
    logic       running;

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= 4'd0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= 4'd0;
            acc     <= '0;
            a_sh    <= a;
            b_sh    <= b;
        end else if (running) begin
            // Bits shifted out of a_sh only affect product bits above 15.
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (cnt == 4'd15);
    assign product = acc;

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: ALU ops take EXEC then WB, MUL spends 16 extra cycles in an iterative multiplier.
// Accepts one instruction only when idle; the register write, done pulse and flag update all happen in WB.
module exec_stage
    import exec_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  reg16_t     instr,
    output logic       instr_ready,
    output reg_sel_t   n,
    output reg_sel_t   m,
    input  reg16_t     rn,
    input  reg16_t     rm,
    output reg_sel_t   d,
    output reg16_t     rd,
    output logic       dw,
    output logic       busy,
    output logic       done,
    output logic [2:0] flags
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t     state;
    state_t     state_nxt;
    reg16_t     instr_q;
    reg16_t     result_q;
    logic       carry_q;
    logic [2:0] flags_q;
    logic [3:0] op_q;
    logic       is_nop;
    reg16_t     add_b;
    logic [16:0] sum17;
    reg16_t     alu_res;
    logic       alu_c;
    logic       mul_start;
    logic       mul_done;
    reg16_t     mul_product;
    reg16_t     wb_result;
    logic [2:0] wb_flags;
    logic       in_wb;

    assign op_q   = get_op(instr_q);
    assign is_nop = op_q[3];
    assign n      = get_n(instr_q);
    assign m      = get_m(instr_q);
    assign d      = get_d(instr_q);

    assign add_b = (op_q == OP_ADDI) ? {13'd0, get_imm(instr_q)} : rm;
    assign sum17 = {1'b0, rn} + {1'b0, add_b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                alu_res = sum17[15:0];
                alu_c   = sum17[16];
            end
            OP_SUB: begin
                alu_res = rn - rm;
                alu_c   = (rn < rm);
            end
            OP_AND:  alu_res = rn & rm;
            OP_OR:   alu_res = rn | rm;
            OP_XOR:  alu_res = rn ^ rm;
            OP_MOV:  alu_res = rn;
            default: ;
        endcase
    end

    assign mul_start = (state == EXEC) && (op_q == OP_MUL);

    mul16_iter u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (rn),
        .b       (rm),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (instr_valid) state_nxt = EXEC;
            EXEC: state_nxt = (op_q == OP_MUL) ? MUL : WB;
            MUL:  if (mul_done) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wb_result = (op_q == OP_MUL) ? mul_product : result_q;
    assign wb_flags  = {(wb_result == 16'd0), wb_result[15], carry_q};
    // A reset landing on the WB cycle suppresses the write and the done pulse.
    assign in_wb     = (state == WB) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            instr_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            flags_q  <= 3'b000;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == EXEC) begin
                result_q <= alu_res;
                carry_q  <= alu_c;
            end
            if (state == WB && !is_nop) begin
                flags_q <= wb_flags;
            end
        end
    end

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = in_wb;
    assign dw          = in_wb && !is_nop;
    assign rd          = wb_result;
    assign flags       = (in_wb && !is_nop) ? wb_flags : flags_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized and directed bench for exec_stage with a behavioural register file and arithmetic reference model.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  n, m, d;
    logic [15:0] rn, rm, rd;
    logic        dw, busy, done;
    logic [2:0]  flags;

    logic [15:0] regs [8];
    logic [15:0] exp_regs [8];
    logic [2:0]  exp_flags;
    logic        ld_en;
    logic [2:0]  ld_sel;
    logic [15:0] ld_val;
    logic        last_dw;
    logic [15:0] last_rd;
    logic [2:0]  last_flags;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .n           (n),
        .m           (m),
        .rn          (rn),
        .rm          (rm),
        .d           (d),
        .rd          (rd),
        .dw          (dw),
        .busy        (busy),
        .done        (done),
        .flags       (flags)
    );

    assign rn = regs[n];
    assign rm = regs[m];

    always @(posedge clk) begin
        if (dw) regs[d] <= rd;
        else if (ld_en) regs[ld_sel] <= ld_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Results straight from the opcode definitions using integer arithmetic.
    function automatic void model(input int op, input int a, input int b, input int imm,
                                  output int res, output int c, output bit wr);
        longint p;
        wr = 1'b1;
        c  = 0;
        res = 0;
        case (op)
            0: begin res = (a + b) % 65536; c = (a + b >= 65536) ? 1 : 0; end
            1: begin res = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a;
            6: begin p = longint'(a) * longint'(b); res = int'(p % 65536); end
            7: begin res = (a + imm) % 65536; c = (a + imm >= 65536) ? 1 : 0; end
            default: wr = 1'b0;
        endcase
    endfunction

    task automatic load(input int sel, input logic [15:0] val);
        ld_en = 1'b1; ld_sel = 3'(sel); ld_val = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
        exp_regs[sel] = val;
    endtask

    task automatic run_instr(input logic [15:0] w, input bit hold, input logic [15:0] nxt);
        int op, a, b, imm, res, c, lat, k;
        bit wr, seen, quiet;
        logic [2:0] ef;
        op  = int'(w[15:12]);
        imm = int'(w[2:0]);
        a   = int'(exp_regs[w[8:6]]);
        b   = int'(exp_regs[w[5:3]]);
        model(op, a, b, imm, res, c, wr);
        ef  = wr ? {(res == 0), (res >= 32768), (c != 0)} : exp_flags;
        lat = (op == 6) ? 18 : 2;
        chk("ready_at_issue", instr_ready, 1);
        instr_valid = 1'b1; instr = w;
        @(posedge clk); #1;
        seen = 0; quiet = 1; k = 1;
        while (!seen && k <= 30) begin
            if (done) begin
                seen = 1;
                last_dw = dw; last_rd = rd; last_flags = flags;
                chk("latency", k, lat);
                chk("dw_wb", dw, wr);
                if (wr) begin
                    chk("d_wb", d, w[11:9]);
                    chk("rd_wb", rd, res[15:0]);
                end
                chk("flags_wb", flags, ef);
                instr_valid = hold;
                instr = hold ? nxt : 16'h0;
            end else begin
                if (dw || !busy || instr_ready) quiet = 0;
                instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                instr = hold ? nxt : 16'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("quiet_while_busy", quiet, 1);
        if (wr) exp_regs[w[11:9]] = res[15:0];
        exp_flags = ef;
        chk("flags_after", flags, ef);
        chk("busy_after", busy, 0);
    endtask

    function automatic logic [15:0] enc(input int op, input int dd, input int nn, input int mm, input int im);
        return {4'(op), 3'(dd), 3'(nn), 3'(mm), 3'(im)};
    endfunction

    initial begin
        logic [2:0] fsave;
        logic [15:0] r6;
        bit quiet;
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; ld_en = 1'b0; ld_sel = 3'd0; ld_val = 16'h0;
        exp_flags = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dw", dw, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 0);
        chk("rst_rd", rd, 0);
        chk("rst_dnm", {d, n, m}, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) load(i, 16'($urandom));

        // ADD overflowing into the sign bit
        load(1, 16'h7FFF); load(2, 16'h0001);
        run_instr(16'h0288, 0, 16'h0);
        chk("add_rd", last_rd, 16'h8000);
        chk("add_flags", last_flags, 3'b010);

        // SUB to zero, then SUB with borrow
        load(3, 16'h1234);
        run_instr(enc(1, 3, 3, 3, 0), 0, 16'h0);
        chk("sub0_rd", last_rd, 16'h0000);
        chk("sub0_flags", last_flags, 3'b100);
        load(1, 16'h0001); load(2, 16'h0002);
        run_instr(enc(1, 5, 1, 2, 0), 0, 16'h0);
        chk("subb_rd", last_rd, 16'hFFFF);
        chk("subb_flags", last_flags, 3'b011);

        // MUL with valid held high; follow-up accepted only once idle again
        load(1, 16'h0100); load(2, 16'h0101);
        run_instr(enc(6, 3, 1, 2, 0), 1, enc(0, 4, 3, 3, 0));
        chk("mul_rd", last_rd, 16'h0100);
        run_instr(enc(0, 4, 3, 3, 0), 0, 16'h0);
        chk("mul_dep_rd", last_rd, 16'h0200);

        // Back-to-back dependent ADDI then ADD
        load(0, 16'h0000);
        run_instr(enc(7, 4, 0, 0, 7), 0, 16'h0);
        run_instr(enc(0, 5, 4, 4, 0), 0, 16'h0);
        chk("dep_rd", last_rd, 16'h000E);

        // NOP leaves flags alone
        fsave = flags;
        run_instr(16'hF123, 0, 16'h0);
        chk("nop_dw", last_dw, 0);
        chk("nop_flags", flags, fsave);

        // Reset in the middle of a MUL
        load(6, 16'h00AA); load(7, 16'h0003);
        r6 = exp_regs[6];
        instr_valid = 1'b1; instr = enc(6, 6, 6, 7, 0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        quiet = 1;
        for (int k = 1; k < 10; k++) begin
            if (dw || done) quiet = 0;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_flags = 3'b000;
        chk("mulrst_flags", flags, 0);
        chk("mulrst_ready", instr_ready, 1);
        for (int k = 0; k < 20; k++) begin
            if (dw || done || busy) quiet = 0;
            @(posedge clk); #1;
        end
        chk("mulrst_quiet", quiet, 1);
        chk("mulrst_r6", regs[6], r6);

        // Reset coinciding with WB wins over the write
        load(1, 16'h0005);
        run_instr(enc(0, 2, 1, 1, 0), 0, 16'h0);
        instr_valid = 1'b1; instr = enc(0, 6, 1, 1, 0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("wbrst_pre_done", done, 1);
        reset = 1'b1;
        #1;
        chk("wbrst_dw", dw, 0);
        chk("wbrst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_flags = 3'b000;
        chk("wbrst_flags", flags, 0);
        chk("wbrst_ready", instr_ready, 1);
        chk("wbrst_r6", regs[6], r6);

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            int op;
            if (i % 10 == 0) load($urandom_range(0, 7), 16'($urandom));
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            run_instr(enc(op, $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7)), 0, 16'h0);
        end

        for (int i = 0; i < 8; i++) chk("regfile", regs[i], exp_regs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
